// File: rtl/arb_pkg.sv
// arb_pkg: shared state encoding and select-width helper for the round-robin mux arbiter.
package arb_pkg;

    typedef enum logic {IDLE, GRANT} state_e;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational rotating-priority search over req, starting at ptr and wrapping.
module rr_priority_pick #(
    parameter int INS = 5,
    parameter int W   = 3
) (
    input  logic [INS-1:0] req,
    input  logic [W-1:0]   ptr,
    output logic           found,
    output logic [W-1:0]   idx,
    output logic [INS-1:0] onehot
);
    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        found = |req;
        idx = '0;
        for (int i = INS - 1; i >= 0; i--)
            if (req[(int'(ptr) + i) % INS]) idx = W'((int'(ptr) + i) % INS);
        onehot = found ? (INS'(1) << idx) : '0;
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter that owns the select of a shared INS:1 mux.
// Optional per-owner hold limit is enabled by defining ARB_HOLD_LIMIT_EN.
module rr_mux_arbiter
    import arb_pkg::*;
#(
    parameter int INS      = 5,
    parameter int MAX_HOLD = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [INS-1:0]        req,
    output logic [INS-1:0]        gnt,
    output logic [sel_w(INS)-1:0] sel,
    output logic                  busy
);
    localparam int W = sel_w(INS);

    state_e         state_q;
    logic [INS-1:0] gnt_q, pick_oh;
    logic [W-1:0]   sel_q, ptr_q, ptr_d, pick_idx;
    logic           busy_q, found, expire, rel;

    rr_priority_pick #(.INS(INS), .W(W)) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .found  (found),
        .idx    (pick_idx),
        .onehot (pick_oh)
    );

    // Arbitration runs whenever there is no owner to keep: idle, owner dropped, or hold expired.
    assign rel   = (state_q == IDLE) || !req[sel_q] || expire;
    assign ptr_d = (pick_idx == W'(INS - 1)) ? '0 : pick_idx + 1'b1;

`ifdef ARB_HOLD_LIMIT_EN
    logic [7:0] hold_q;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) hold_q <= '0;
        else          hold_q <= rel ? '0 : hold_q + 8'd1;

    assign expire = (state_q == GRANT) && (hold_q == 8'(MAX_HOLD - 1));
`else
    assign expire = MAX_HOLD < 0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else if (rel) begin
            state_q <= found ? GRANT : IDLE;
            gnt_q   <= pick_oh;
            busy_q  <= found;
            if (found) begin
                sel_q <= pick_idx;
                ptr_q <= ptr_d;
            end
        end
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed stimulus with a rule-level ownership model checked every cycle.
module tb_rr_mux_arbiter;
    localparam int INS      = 5;
    localparam int MAX_HOLD = 4;
`ifdef ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset_n;
    logic [INS-1:0] req = '0;
    logic [INS-1:0] gnt;
    logic [2:0]     sel;
    logic           busy;

    int checks = 0;
    int errors = 0;

    int m_own  = -1;
    int m_ptr  = 0;
    int m_sel  = 0;
    int m_held = 0;
    int w;

    rr_mux_arbiter #(.INS(INS), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [INS-1:0] r, input int p);
        for (int i = 0; i < INS; i++)
            if (r[(p + i) % INS]) return (p + i) % INS;
        return -1;
    endfunction

    // Ownership model: who owns the mux, where priority starts, how long the owner has held.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_own = -1; m_ptr = 0; m_sel = 0; m_held = 0;
        end else if (m_own < 0 || !req[m_own] || (HOLD_EN && m_held == MAX_HOLD)) begin
            w = pick(req, m_ptr);
            m_own = w;
            m_held = 1;
            if (w >= 0) begin
                m_sel = w;
                m_ptr = (w + 1) % INS;
            end
        end else begin
            m_held++;
        end
    end

    always @(negedge clk)
        if (reset_n) begin
            chk("gnt_model", 32'(gnt), (m_own < 0) ? 32'd0 : 32'd1 << m_own);
            chk("busy_model", 32'(busy), 32'(m_own >= 0));
            chk("sel_model", 32'(sel), 32'(m_sel));
        end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req = '0;
        cyc(3);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        do_reset();
        cyc(10);
        chk("reset_gnt", 32'(gnt), 0);
        chk("reset_sel", 32'(sel), 0);
        chk("reset_busy", 32'(busy), 0);

        req = 5'b00100;
        cyc(1);
        chk("single_gnt", 32'(gnt), 32'b00100);
        chk("single_sel", 32'(sel), 2);
        chk("single_busy", 32'(busy), 1);
        req = '0;
        cyc(1);
        chk("single_release_busy", 32'(busy), 0);
        chk("single_release_sel_kept", 32'(sel), 2);

        do_reset();
        req = 5'b11111;
        cyc(1);
        for (int k = 0; k < INS; k++) begin
            chk("rr_order_gnt", 32'(gnt), 32'd1 << k);
            chk("rr_order_sel", 32'(sel), k);
            cyc(2);
            req[k] = 1'b0;
            cyc(1);
        end
        chk("rr_all_released", 32'(busy), 0);

        req = 5'b01000;
        cyc(1);
        chk("wrap_setup_gnt3", 32'(gnt), 32'b01000);
        req = '0;
        cyc(1);
        req = 5'b00011;
        cyc(1);
        chk("wrap_first_gnt0", 32'(gnt), 32'b00001);
        req[0] = 1'b0;
        cyc(1);
        chk("wrap_next_gnt1", 32'(gnt), 32'b00010);
        chk("wrap_next_sel1", 32'(sel), 1);
        req = '0;
        cyc(1);

        req = 5'b00011;
        cyc(1);
        chk("hold_first_gnt0", 32'(gnt), 32'b00001);
`ifdef ARB_HOLD_LIMIT_EN
        cyc(MAX_HOLD);
        chk("hold_forced_gnt1", 32'(gnt), 32'b00010);
        cyc(MAX_HOLD);
        chk("hold_back_gnt0", 32'(gnt), 32'b00001);
`else
        cyc(12);
        chk("hold_permanent_gnt0", 32'(gnt), 32'b00001);
`endif
        req = '0;
        cyc(1);

        req = 5'b01000;
        cyc(1);
        chk("midreset_setup_gnt3", 32'(gnt), 32'b01000);
        #3 reset_n = 1'b0;
        #1;
        chk("midreset_gnt", 32'(gnt), 0);
        chk("midreset_busy", 32'(busy), 0);
        chk("midreset_sel", 32'(sel), 0);
        cyc(1);
        req = 5'b10010;
        reset_n = 1'b1;
        cyc(1);
        chk("midreset_ptr_restart", 32'(gnt), 32'b00010);
        req = '0;
        cyc(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
